// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake/control bundle between the 5-stage pipeline datapath and its hazard controller.
// master = datapath side (drives hazard sources), slave = controller (drives enables, stats).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ex_wreg;
    logic             ex_m2reg;
    logic [4:0]       ex_rn;
    logic             ex_br_taken;
    logic             dmem_busy;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_we;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_err;
    logic             state;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_rn,
               ex_br_taken, dmem_busy,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we,
               stall_cnt, flush_cnt, mem_err, state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_rn,
               ex_br_taken, dmem_busy,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we,
               stall_cnt, flush_cnt, mem_err, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, dmem freeze, stats, timeout.
// Zero-cycle combinational controls; dmem_busy freezes every stage (highest after clr).
module pipe_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int MW_MAX = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    pipe_hazard_ctrl_if.slave       bus
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] MWAIT = 1'b1;
    localparam int         WW    = $clog2(MW_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             lu;
    logic             flush;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_we;
    logic [0:0]       state_q;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             mem_err_q;

    // Register 0 is hardwired, so a write to it can never feed a dependent read.
    assign lu = bus.ex_wreg & bus.ex_m2reg & (bus.ex_rn != 5'd0) &
                ((bus.id_use_rs & (bus.id_rs == bus.ex_rn)) |
                 (bus.id_use_rt & (bus.id_rt == bus.ex_rn)));

    // Only a flush that actually happens counts; a frozen branch waits its turn.
    assign flush = ~bus.dmem_busy & bus.ex_br_taken;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        if (clr) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b0;
        end else if (bus.dmem_busy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (bus.ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= RUN;
            wait_cnt  <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= bus.dmem_busy ? MWAIT : RUN;
            if (!bus.dmem_busy)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MW_MAX))
                wait_cnt <= wait_cnt + 1'b1;
            // Sticky: set on the edge wait_cnt reaches MW_MAX, cleared only by clr.
            if (bus.dmem_busy && (wait_cnt == WW'(MW_MAX - 1)))
                mem_err_q <= 1'b1;
            if (!pc_we && (stall_q != CNT_MAX))
                stall_q <= stall_q + 1'b1;
            if (flush && (flush_q != CNT_MAX))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_we    = exmem_we;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 16-bit-counter instance and a 2-bit one fed identical stimulus.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] id_rs, id_rt, ex_rn;
    logic       id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_br_taken, dmem_busy;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  bus_b ();

    assign bus_a.id_rs = id_rs;         assign bus_b.id_rs = id_rs;
    assign bus_a.id_rt = id_rt;         assign bus_b.id_rt = id_rt;
    assign bus_a.id_use_rs = id_use_rs; assign bus_b.id_use_rs = id_use_rs;
    assign bus_a.id_use_rt = id_use_rt; assign bus_b.id_use_rt = id_use_rt;
    assign bus_a.ex_wreg = ex_wreg;     assign bus_b.ex_wreg = ex_wreg;
    assign bus_a.ex_m2reg = ex_m2reg;   assign bus_b.ex_m2reg = ex_m2reg;
    assign bus_a.ex_rn = ex_rn;         assign bus_b.ex_rn = ex_rn;
    assign bus_a.ex_br_taken = ex_br_taken; assign bus_b.ex_br_taken = ex_br_taken;
    assign bus_a.dmem_busy = dmem_busy; assign bus_b.dmem_busy = dmem_busy;

    pipe_hazard_ctrl #(.CNT_W(16), .MW_MAX(8)) dut_a (.clk(clk), .clr(clr), .bus(bus_a.slave));
    pipe_hazard_ctrl #(.CNT_W(2),  .MW_MAX(8)) dut_b (.clk(clk), .clr(clr), .bus(bus_b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Order: pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we.
    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, bus_a.pc_we, bus_a.ifid_we, bus_a.ifid_flush,
                  bus_a.idex_bubble, bus_a.exmem_we}, {27'd0, exp});
    endtask

    task automatic chk_regs(input string tag, input logic st, input int stall,
                            input int flush, input logic merr);
        chk({tag, ".state"}, {31'd0, bus_a.state}, {31'd0, st});
        chk({tag, ".stall"}, {16'd0, bus_a.stall_cnt}, stall);
        chk({tag, ".flush"}, {16'd0, bus_a.flush_cnt}, flush);
        chk({tag, ".merr"},  {31'd0, bus_a.mem_err}, {31'd0, merr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rn = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        ex_br_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    localparam logic [4:0] C_CLR    = 5'b00110;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_FLUSH  = 5'b11111;
    localparam logic [4:0] C_LU     = 5'b00011;
    localparam logic [4:0] C_NORM   = 5'b11001;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1;
        idle_inputs();
        #1 chk_ctrl("clr_ctrl", C_CLR);
        tick();
        chk_regs("reset", 1'b0, 0, 0, 1'b0);
        chk("reset.b_stall", {30'd0, bus_b.stall_cnt}, 0);

        clr = 1'b0;
        #1 chk_ctrl("idle_ctrl", C_NORM);
        tick();
        chk_regs("idle", 1'b0, 0, 0, 1'b0);

        // Load-use on rs: one-cycle stall, then the bubble clears it.
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        #1 chk_ctrl("lu_rs_ctrl", C_LU);
        tick();
        chk("lu_rs.stall", {16'd0, bus_a.stall_cnt}, 1);
        ex_m2reg = 1'b0;
        #1 chk_ctrl("after_lu_ctrl", C_NORM);
        tick();
        chk("after_lu.stall", {16'd0, bus_a.stall_cnt}, 1);

        ex_m2reg = 1'b1; ex_rn = 5'd0; id_rs = 5'd0;
        #1 chk_ctrl("r0_ctrl", C_NORM);
        tick();
        id_use_rs = 1'b0; ex_rn = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
        #1 chk_ctrl("rt_unused_ctrl", C_NORM);
        tick();
        chk("no_hazard.stall", {16'd0, bus_a.stall_cnt}, 1);
        id_use_rt = 1'b1;
        #1 chk_ctrl("lu_rt_ctrl", C_LU);
        tick();
        chk("lu_rt.stall", {16'd0, bus_a.stall_cnt}, 2);
        chk("lu_rt.b_stall", {30'd0, bus_b.stall_cnt}, 2);

        // Taken branch together with a live load-use: flush wins, no stall.
        ex_br_taken = 1'b1;
        #1 chk_ctrl("br_lu_ctrl", C_FLUSH);
        tick();
        chk_regs("br_lu", 1'b0, 2, 1, 1'b0);

        // Freeze holds a pending branch for 3 cycles.
        ex_wreg = 1'b0; ex_m2reg = 1'b0; id_use_rt = 1'b0; dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctrl("freeze_ctrl", C_FREEZE);
            tick();
            chk("freeze.state", {31'd0, bus_a.state}, 1);
        end
        chk_regs("freeze3", 1'b1, 5, 1, 1'b0);
        dmem_busy = 1'b0;
        #1 chk_ctrl("post_freeze_br_ctrl", C_FLUSH);
        tick();
        chk_regs("post_freeze_br", 1'b0, 5, 2, 1'b0);
        ex_br_taken = 1'b0;

        // Seven busy cycles stay below the timeout.
        dmem_busy = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk_regs("busy7", 1'b1, 12, 2, 1'b0);
        chk("busy7.b_stall_sat", {30'd0, bus_b.stall_cnt}, 3);
        dmem_busy = 1'b0;
        tick();
        chk_regs("busy7_end", 1'b0, 12, 2, 1'b0);

        // Eight busy cycles trip the sticky timeout on the 8th edge.
        dmem_busy = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("busy8.pre_merr", {31'd0, bus_a.mem_err}, 0);
        #1 chk_ctrl("timeout_ctrl", C_FREEZE);
        tick();
        chk_regs("busy8", 1'b1, 20, 2, 1'b1);
        chk("busy8.b_merr", {31'd0, bus_b.mem_err}, 1);
        dmem_busy = 1'b0;
        tick();
        chk_regs("busy8_end", 1'b0, 20, 2, 1'b1);

        // clr in the middle of a freeze.
        dmem_busy = 1'b1;
        tick();
        chk("pre_clr.state", {31'd0, bus_a.state}, 1);
        clr = 1'b1;
        #1 chk_ctrl("clr_busy_ctrl", C_CLR);
        tick();
        chk_regs("clr_mid", 1'b0, 0, 0, 1'b0);
        chk("clr_mid.b_flush", {30'd0, bus_b.flush_cnt}, 0);
        clr = 1'b0;
        #1 chk_ctrl("rel_busy_ctrl", C_FREEZE);
        tick();
        chk_regs("rel_busy", 1'b1, 1, 0, 1'b0);
        dmem_busy = 1'b0;
        tick();
        chk("final.state", {31'd0, bus_a.state}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the PC write enable and the write-enable and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use stalls, taken-branch flushes and data-memory wait freezes. It also keeps stall/flush statistics and a data-memory timeout flag.

## Interface
Parameters:
- CNT_W, 16, width of statistic counters
- MW_MAX, 8, consecutive dmem_busy cycles that set mem_err (≥1)

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- clr  in  1  synchronous reset, active-high
- id_rs, id_rt  in  5  source register numbers of instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- ex_wreg  in  1  EX instruction writes register file
- ex_m2reg  in  1  EX instruction is a load
- ex_rn  in  5  EX destination register
- ex_br_taken  in  1  branch/jump in EX resolved taken
- dmem_busy  in  1  MEM-stage data memory not ready this cycle
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID loads nop (zero) at next edge
- idex_bubble  out  1  ID/EX loads nop at next edge
- exmem_we  out  1  EX/MEM write enable
- stall_cnt  out  CNT_W  cycles with pc_we=0 since reset (saturating)
- flush_cnt  out  CNT_W  taken-branch flushes since reset (saturating)
- mem_err  out  1  sticky data-memory timeout flag
- state  out  1  0=RUN, 1=MWAIT

## Operation
- Control outputs are combinational from current inputs, with fixed priority:
  1. clr=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_we=0.
  2. dmem_busy=1 (freeze): pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, exmem_we=0. All stages hold. A pending branch in EX is held and is serviced after the freeze.
  3. ex_br_taken=1 (flush): pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_we=1.
  4. load-use (lu): pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, exmem_we=1.
  5. otherwise: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, exmem_we=1.
- lu = ex_wreg & ex_m2reg & (ex_rn≠0) & ((id_use_rs & id_rs==ex_rn) | (id_use_rt & id_rt==ex_rn)).
- A register number of 0 never creates a hazard.
- FSM:
  - RUN→MWAIT when dmem_busy=1.
  - MWAIT stays while dmem_busy=1.
  - MWAIT→RUN when dmem_busy=0.
- wait_cnt (internal, saturating at MW_MAX):
  - cleared in any cycle with dmem_busy=0.
  - incremented in each cycle with dmem_busy=1.
  - mem_err is set at the edge where wait_cnt reaches MW_MAX.
  - mem_err stays 1 until clr. The freeze continues regardless.
- stall_cnt +1 per non-reset cycle with pc_we=0. flush_cnt +1 per non-reset cycle in priority 3. Both counters saturate at 2^CNT_W−1.

## Timing
- Reset values after the clr edge: state=RUN, stall_cnt=0, flush_cnt=0, mem_err=0, wait_cnt=0.
- Control outputs take their clr values in the same cycle clr is high.
- Control outputs have zero-cycle latency: a hazard is acted on in the cycle it is visible.
- A load-use stall lasts exactly 1 cycle. After the edge, ex_m2reg comes from the bubble, so lu=0.
- A taken branch costs 2 slots (IF/ID and ID/EX zeroed at the same edge). PC takes the target at that edge.
- Simultaneous ex_br_taken and lu: the flush wins, no stall. The ID instruction is discarded anyway.
- Simultaneous dmem_busy and anything else: the freeze wins, and counters see a stall cycle.
- clr asserted mid-freeze: the next edge returns to RUN with counters zeroed, even if dmem_busy is still 1.
- After clr releases with dmem_busy=1, the FSM enters MWAIT at the next edge.

## Test plan
- Load-use: ex_wreg=1, ex_m2reg=1, ex_rn=5, id_rs=5, id_use_rs=1 for one cycle → pc_we=0, ifid_we=0, idex_bubble=1 that cycle; stall_cnt goes 0→1; next cycle (ex_m2reg=0) outputs are normal.
- R0 exemption and unused operand: ex_rn=0 with id_rs=0 → no stall. ex_rn=7, id_rt=7, id_use_rt=0 → no stall.
- Branch flush plus lu in the same cycle: ex_br_taken=1 with lu true → pc_we=1, ifid_flush=1, idex_bubble=1; flush_cnt=1, stall_cnt unchanged.
- Freeze with pending branch: dmem_busy=1 for 3 cycles with ex_br_taken=1 → all enables 0, state=1, stall_cnt=3. On the 4th cycle (busy=0) flush outputs assert, state returns to 0, flush_cnt=1.
- Timeout: MW_MAX=8, dmem_busy=1 for 8 cycles → mem_err=1 after the 8th edge. mem_err stays 1 after busy drops. A 7-cycle busy run alone does not set it.
- Reset mid-freeze and saturation:
  - clr during MWAIT → state=0, counters=0, mem_err=0 next cycle.
  - With CNT_W=2, 5 stall cycles → stall_cnt=3.
